// File: rtl/spad_arbiter.sv
// spad_arbiter: one SPad shared by NUM_RD round-robin readers and two fixed-priority writers (anti-starvation).
// Grants are combinational, rd_valid follows one cycle later; define SPAD_ARB_BYPASS_EN for same-address RAW forwarding.
module spad_arbiter #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 9,
  parameter int NUM_RD        = 3,
  parameter int MAX_WAIT      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_RD-1:0]             rd_req,
  input  logic [NUM_RD*ADDR_BITWIDTH-1:0] rd_addr,
  output logic [NUM_RD-1:0]             rd_gnt,
  output logic [NUM_RD-1:0]             rd_valid,
  output logic [DATA_BITWIDTH-1:0]      rd_data,
  input  logic [1:0]                    wr_req,
  input  logic [2*ADDR_BITWIDTH-1:0]    wr_addr,
  input  logic [2*DATA_BITWIDTH-1:0]    wr_data,
  output logic [1:0]                    wr_gnt,
  output logic                          spad_read_req,
  output logic [ADDR_BITWIDTH-1:0]      spad_r_addr,
  output logic                          spad_write_en,
  output logic [ADDR_BITWIDTH-1:0]      spad_w_addr,
  output logic [DATA_BITWIDTH-1:0]      spad_w_data,
  input  logic [DATA_BITWIDTH-1:0]      spad_r_data
);
  localparam int PTR_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int SUM_W = PTR_W + 1;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [PTR_W-1:0] LAST_RD  = PTR_W'(NUM_RD - 1);
  localparam logic [SUM_W-1:0] NUM_RD_S = SUM_W'(NUM_RD);
  localparam logic [CNT_W-1:0] WAIT_SAT = CNT_W'(MAX_WAIT);

  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    rd_off;
  logic [PTR_W-1:0]    rd_win;
  logic [SUM_W-1:0]    rd_sum;
  logic [SUM_W-1:0]    rd_wrap;
  logic [2*NUM_RD-1:0] req_dbl;
  logic                rd_any;
  logic [CNT_W-1:0]    wait_cnt;
  logic                w1_win;

  // Rotate requests so bit 0 is the reader at rr_ptr; the lowest set bit is the winner.
  always_comb begin
    req_dbl     = {rd_req, rd_req} >> rr_ptr;
    rd_off      = '0;
    for (int j = NUM_RD - 1; j >= 0; j--) begin
      if (req_dbl[j]) rd_off = PTR_W'(j);
    end
    rd_sum      = {1'b0, rr_ptr} + {1'b0, rd_off};
    rd_wrap     = rd_sum - NUM_RD_S;
    rd_win      = (rd_sum >= NUM_RD_S) ? rd_wrap[PTR_W-1:0] : rd_sum[PTR_W-1:0];
    rd_any      = (|rd_req) && !reset;
    rd_gnt      = '0;
    spad_r_addr = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_any && (rd_win == PTR_W'(i))) begin
        rd_gnt[i]   = 1'b1;
        spad_r_addr = rd_addr[i*ADDR_BITWIDTH +: ADDR_BITWIDTH];
      end
    end
    spad_read_req = rd_any;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      rd_valid <= '0;
    end else begin
      rd_valid <= rd_gnt;
      if (rd_any) rr_ptr <= (rd_win == LAST_RD) ? '0 : rd_win + 1'b1;
    end
  end

  // Writer 1 only overtakes writer 0 once it has been denied MAX_WAIT cycles in a row.
  assign w1_win = wr_req[1] && (!wr_req[0] || (wait_cnt == WAIT_SAT));

  always_comb begin
    wr_gnt        = '0;
    spad_write_en = 1'b0;
    spad_w_addr   = '0;
    spad_w_data   = '0;
    if (!reset && (|wr_req)) begin
      spad_write_en = 1'b1;
      if (w1_win) begin
        wr_gnt      = 2'b10;
        spad_w_addr = wr_addr[2*ADDR_BITWIDTH-1:ADDR_BITWIDTH];
        spad_w_data = wr_data[2*DATA_BITWIDTH-1:DATA_BITWIDTH];
      end else begin
        wr_gnt      = 2'b01;
        spad_w_addr = wr_addr[ADDR_BITWIDTH-1:0];
        spad_w_data = wr_data[DATA_BITWIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (wr_req[1] && !w1_win) begin
      if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

`ifdef SPAD_ARB_BYPASS_EN
  logic                     byp_hit;
  logic [DATA_BITWIDTH-1:0] byp_data;
  logic                     byp_match;

  // The SPad returns the pre-write value on a same-cycle collision; forward the new word instead.
  assign byp_match = spad_read_req && spad_write_en && (spad_r_addr == spad_w_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit <= byp_match;
      if (byp_match) byp_data <= spad_w_data;
    end
  end

  assign rd_data = byp_hit ? byp_data : spad_r_data;
`else
  assign rd_data = spad_r_data;
`endif

endmodule

// File: tb/tb_spad_arbiter.sv
// Directed bench for spad_arbiter with a behavioural 1-read/1-write SPad (registered read, old-value on collision).
module tb_spad_arbiter;
  localparam int DW = 16;
  localparam int AW = 9;
  localparam int NR = 3;
  localparam int MW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   rd_req;
  logic [NR*AW-1:0] rd_addr;
  logic [NR-1:0]   rd_gnt;
  logic [NR-1:0]   rd_valid;
  logic [DW-1:0]   rd_data;
  logic [1:0]      wr_req;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic [1:0]      wr_gnt;
  logic            spad_read_req;
  logic [AW-1:0]   spad_r_addr;
  logic            spad_write_en;
  logic [AW-1:0]   spad_w_addr;
  logic [DW-1:0]   spad_w_data;
  logic [DW-1:0]   spad_r_data;
  logic            mem_init;
  logic [DW-1:0]   mem [0:511];

  int checks = 0;
  int errors = 0;

  spad_arbiter #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .NUM_RD(NR), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .spad_read_req(spad_read_req), .spad_r_addr(spad_r_addr),
    .spad_write_en(spad_write_en), .spad_w_addr(spad_w_addr), .spad_w_data(spad_w_data),
    .spad_r_data(spad_r_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int a);
    return (a == 7) ? 16'h0055 : 16'h0100 + 16'(a);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
      spad_r_data <= '0;
    end else begin
      if (spad_read_req) spad_r_data <= mem[spad_r_addr];
      if (spad_write_en) mem[spad_w_addr] <= spad_w_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int exp_raddr(input logic [2:0] g);
    case (g)
      3'b001:  return 10;
      3'b010:  return 20;
      3'b100:  return 30;
      default: return 0;
    endcase
  endfunction

  logic [2:0] rr_tab [0:5]   = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [1:0] wreq_tab [0:14] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01,
                                  2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00};
  logic [1:0] wgnt_tab [0:14] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01,
                                  2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00};

  initial begin
    logic [15:0] exp_byp;
    reset    = 1'b1;
    mem_init = 1'b1;
    rd_req   = '0;
    wr_req   = '0;
    rd_addr  = {9'd30, 9'd20, 9'd10};
    wr_addr  = {9'd101, 9'd100};
    wr_data  = {16'hBBBB, 16'hAAAA};
    repeat (2) @(posedge clk);
    #2;
    rd_req = 3'b111;
    wr_req = 2'b11;
    #1;
    check("rst_rd_gnt", rd_gnt, 0);
    check("rst_wr_gnt", wr_gnt, 0);
    check("rst_rreq", spad_read_req, 0);
    check("rst_wen", spad_write_en, 0);
    check("rst_rd_valid", rd_valid, 0);
    mem_init = 1'b0;
    reset    = 1'b0;
    #1;
    check("rel_rd_gnt", rd_gnt, 3'b001);
    check("rel_wr_gnt", wr_gnt, 2'b01);
    @(posedge clk); #2;
    check("pre_rst_valid", rd_valid, 3'b001);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_rd_gnt", rd_gnt, 0);
    check("mid_rst_wr_gnt", wr_gnt, 0);
    check("mid_rst_rreq", spad_read_req, 0);
    check("mid_rst_wen", spad_write_en, 0);
    @(posedge clk); #2;
    reset  = 1'b0;
    wr_req = 2'b00;
    #1;

    for (int i = 0; i < 6; i++) begin
      check("rr_gnt", rd_gnt, rr_tab[i]);
      check("rr_raddr", spad_r_addr, exp_raddr(rr_tab[i]));
      if (i > 0) begin
        check("rr_valid", rd_valid, rr_tab[i-1]);
        check("rr_data", rd_data, init_val(exp_raddr(rr_tab[i-1])));
      end
      @(posedge clk); #3;
    end
    check("rr_valid_last", rd_valid, 3'b100);
    check("rr_data_last", rd_data, init_val(30));

    rd_req = 3'b001;
    #1;
    check("skip_pre_gnt", rd_gnt, 3'b001);
    @(posedge clk); #2;
    rd_req = 3'b101;
    #1;
    check("skip_gnt0", rd_gnt, 3'b100);
    @(posedge clk); #3;
    check("skip_gnt1", rd_gnt, 3'b001);
    check("skip_valid", rd_valid, 3'b100);
    check("skip_data", rd_data, init_val(30));
    @(posedge clk); #3;
    check("skip_gnt2", rd_gnt, 3'b100);
    rd_req = 3'b000;
    #1;
    check("idle_rreq", spad_read_req, 0);
    check("idle_raddr", spad_r_addr, 0);
    check("idle_gnt", rd_gnt, 0);
    @(posedge clk); #2;

    for (int c = 0; c < 15; c++) begin
      wr_req = wreq_tab[c];
      #1;
      check("wr_gnt", wr_gnt, wgnt_tab[c]);
      check("wr_en", spad_write_en, (wgnt_tab[c] != 2'b00) ? 1 : 0);
      check("wr_addr", spad_w_addr, (wgnt_tab[c] == 2'b01) ? 100 : (wgnt_tab[c] == 2'b10) ? 101 : 0);
      check("wr_data", spad_w_data, (wgnt_tab[c] == 2'b01) ? 16'hAAAA : (wgnt_tab[c] == 2'b10) ? 16'hBBBB : 16'h0);
      @(posedge clk); #2;
    end

`ifdef SPAD_ARB_BYPASS_EN
    exp_byp = 16'h1234;
`else
    exp_byp = 16'h0055;
`endif
    rd_addr = {9'd30, 9'd20, 9'd7};
    wr_addr = {9'd101, 9'd7};
    wr_data = {16'hBBBB, 16'h1234};
    rd_req  = 3'b001;
    wr_req  = 2'b01;
    #1;
    check("haz_rd_gnt", rd_gnt, 3'b001);
    check("haz_wr_gnt", wr_gnt, 2'b01);
    check("haz_raddr", spad_r_addr, 7);
    @(posedge clk); #2;
    wr_req = 2'b00;
    #1;
    check("haz_valid", rd_valid, 3'b001);
    check("haz_data", rd_data, exp_byp);
    @(posedge clk); #2;
    rd_addr = {9'd30, 9'd20, 9'd10};
    #1;
    check("haz_reread", rd_data, 16'h1234);
    @(posedge clk); #2;
    rd_req = 3'b000;
    #1;
    check("haz_after", rd_data, init_val(10));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
